pc_fetch_unit: RTL and testbench

//  PC register and instruction-fetch sequencer for the multi-cycle MIPS core.

---
 rtl/pc_fetch_if.sv | 26 ++
 rtl/pc_fetch_unit.sv | 117 +++++++++++
 tb/tb_pc_fetch_unit.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Signal bundle between the fetch unit, the core controller, the next-PC stage and instruction memory.
// The fetch unit connects through the slave modport; the controller/memory side uses master.
interface pc_fetch_if;
    logic        fetch_go;
    logic        pc_we;
    logic [31:0] npc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        work_IF;
    logic        fetch_busy;
    logic        fetch_err;

    modport master (
        output fetch_go, pc_we, npc, imem_ack, imem_rdata,
        input  pc, imem_req, imem_addr, ir, work_IF, fetch_busy, fetch_err
    );

    modport slave (
        input  fetch_go, pc_we, npc, imem_ack, imem_rdata,
        output pc, imem_req, imem_addr, ir, work_IF, fetch_busy, fetch_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and req/ack instruction-fetch sequencer for the multi-cycle MIPS core.
// Optional build macro PCF_ALIGN_CHK_EN: error on misaligned fetch instead of forcing pc[1:0]=0.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0000
) (
    input logic       clk,
    input logic       rstn,
    pc_fetch_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    state_t           state, state_nxt;
    logic [31:0]      pc_q, ir_q, pend_pc;
    logic             pend_pc_vld, pend_go;
    logic [CNT_W-1:0] wait_cnt;
    logic             start, launch, misaligned, timeout;

    function automatic logic [31:0] load_val(input logic [31:0] v);
`ifdef PCF_ALIGN_CHK_EN
        return v;
`else
        return v & 32'hFFFF_FFFC;
`endif
    endfunction

`ifdef PCF_ALIGN_CHK_EN
    assign misaligned = (pc_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // A same-cycle pc_we defers the fetch by one cycle so it uses the freshly loaded pc.
    assign start   = (state == S_IDLE) && (bus.fetch_go || pend_go);
    assign launch  = start && !bus.pc_we;
    assign timeout = (state == S_REQ) && !bus.imem_ack
                     && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (launch) state_nxt = misaligned ? S_ERR : S_REQ;
            S_REQ:   if (bus.imem_ack) state_nxt = S_DONE;
                     else if (timeout) state_nxt = S_ERR;
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req   = 1'b0;
        bus.work_IF    = 1'b0;
        bus.fetch_busy = 1'b0;
        bus.fetch_err  = 1'b0;
        case (state)
            S_REQ:   begin bus.imem_req = 1'b1; bus.fetch_busy = 1'b1; end
            S_DONE:  begin bus.work_IF  = 1'b1; bus.fetch_busy = 1'b1; end
            S_ERR:   bus.fetch_err = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc        = pc_q;
    assign bus.ir        = ir_q;
    assign bus.imem_addr = {pc_q[31:2], 2'b00};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q        <= load_val(RESET_PC);
            ir_q        <= NOP_INSTR;
            pend_pc     <= '0;
            pend_pc_vld <= 1'b0;
            pend_go     <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (bus.pc_we) begin
                        pc_q    <= load_val(bus.npc);
                        pend_go <= start;
                    end else begin
                        pend_go <= 1'b0;
                    end
                    if (launch && misaligned) ir_q <= NOP_INSTR;
                end
                S_REQ: begin
                    if (bus.imem_ack)  ir_q <= bus.imem_rdata;
                    else if (timeout)  ir_q <= NOP_INSTR;
                    else               wait_cnt <= wait_cnt + CNT_W'(1);
                    if (bus.pc_we) begin
                        pend_pc     <= bus.npc;
                        pend_pc_vld <= 1'b1;
                    end
                end
                S_DONE: begin
                    // A pc_we in this last busy cycle is the newest value and wins.
                    if (bus.pc_we)        pc_q <= load_val(bus.npc);
                    else if (pend_pc_vld) pc_q <= load_val(pend_pc);
                    pend_pc_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: randomized fetches against a transaction-level PC/IR model.
module tb_pc_fetch_unit;
    localparam logic [31:0] RESET_PC    = 32'h0000_3000;
    localparam int unsigned TIMEOUT_CYC = 16;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
    } done_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    pc_fetch_if bus ();

    pc_fetch_unit #(
        .RESET_PC(RESET_PC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] addr_q[$];
    done_t       done_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ir;

    bit          prev_req = 1'b0;
    bit          prev_wif = 1'b0;
    logic [31:0] held_addr;
    logic [31:0] exp_addr;
    done_t       exp_done;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Architectural PC load rule
    function automatic logic [31:0] pc_of(input logic [31:0] v);
`ifdef PCF_ALIGN_CHK_EN
        return v;
`else
        return {v[31:2], 2'b00};
`endif
    endfunction

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_req = 1'b0;
                prev_wif = 1'b0;
            end else begin
                if (bus.imem_req && !prev_req) begin
                    check("req_expected", 32'(addr_q.size() != 0), 32'd1);
                    if (addr_q.size() != 0) begin
                        exp_addr = addr_q.pop_front();
                        check("imem_addr", bus.imem_addr, exp_addr);
                    end
                    held_addr = bus.imem_addr;
                end else if (bus.imem_req) begin
                    check("imem_addr_stable", bus.imem_addr, held_addr);
                end
                if (bus.work_IF) begin
                    check("work_if_single", 32'(prev_wif), 32'd0);
                    check("done_expected", 32'(done_q.size() != 0), 32'd1);
                    if (done_q.size() != 0) begin
                        exp_done = done_q.pop_front();
                        check("ir_on_work_if", bus.ir, exp_done.ir);
                        check("pc_on_work_if", bus.pc, exp_done.pc);
                    end
                end
                prev_req = bus.imem_req;
                prev_wif = bus.work_IF;
            end
        end
    end

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rstn = 1'b0;
        addr_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #1;
        m_pc = pc_of(RESET_PC);
        m_ir = NOP_INSTR;
        check("rst_pc", bus.pc, m_pc);
        check("rst_ir", bus.ir, m_ir);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_work_if", 32'(bus.work_IF), 32'd0);
        check("rst_err", 32'(bus.fetch_err), 32'd0);
        check("rst_busy", 32'(bus.fetch_busy), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!bus.imem_req && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = bus.imem_req;
    endtask

    task automatic run_fetch(input logic [31:0] rdata, input int delay,
                             input bit load, input logic [31:0] load_npc,
                             input int n_we, input logic [31:0] we0, input logic [31:0] we1);
        bit          ok;
        logic [31:0] fetch_pc;
        logic [31:0] final_pc;
        if (load) m_pc = pc_of(load_npc);
        fetch_pc = m_pc;
        addr_q.push_back(fetch_pc);
        done_q.push_back('{ir: rdata, pc: fetch_pc});
        bus.fetch_go = 1'b1;
        bus.pc_we    = load;
        bus.npc      = load_npc;
        @(posedge clk);
        #1;
        bus.fetch_go = 1'b0;
        bus.pc_we    = 1'b0;
        if (load) check("pc_load_with_go", bus.pc, fetch_pc);
        wait_req(ok);
        check("req_seen", 32'(ok), 32'd1);
        final_pc = fetch_pc;
        for (int c = 0; c <= delay; c++) begin
            bus.imem_ack   = (c == delay);
            bus.imem_rdata = (c == delay) ? rdata : $urandom();
            if (c < n_we) begin
                bus.pc_we = 1'b1;
                bus.npc   = (c == 0) ? we0 : we1;
                final_pc  = pc_of(bus.npc);
            end
            @(posedge clk);
            #1;
            bus.pc_we = 1'b0;
        end
        bus.imem_ack = 1'b0;
        @(posedge clk);
        #1;
        m_pc = final_pc;
        m_ir = rdata;
        check("pc_after_fetch", bus.pc, m_pc);
        check("ir_after_fetch", bus.ir, m_ir);
        check("idle_after_fetch", 32'(bus.fetch_busy), 32'd0);
    endtask

    task automatic load_pc(input logic [31:0] v);
        bus.pc_we = 1'b1;
        bus.npc   = v;
        @(posedge clk);
        #1;
        bus.pc_we = 1'b0;
        m_pc = pc_of(v);
        check("pc_load_idle", bus.pc, m_pc);
    endtask

    task automatic stray_ack();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = $urandom();
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        check("ir_ignores_stray_ack", bus.ir, m_ir);
        check("no_req_after_stray_ack", 32'(bus.imem_req), 32'd0);
    endtask

    initial begin : stimulus
        bit ok;
        int n;
        bus.fetch_go   = 1'b0;
        bus.pc_we      = 1'b0;
        bus.npc        = '0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        do_reset();

        // Directed cases from the fetch protocol description
        run_fetch(32'h2008_0005, 3, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        run_fetch($urandom(), 1, 1'b1, 32'h0000_3010, 0, 32'h0, 32'h0);
        load_pc(32'h0000_3000);
        run_fetch($urandom(), 2, 1'b0, 32'h0, 2, 32'h0000_3020, 32'h0000_3024);
        check("pc_last_pending_wins", bus.pc, 32'h0000_3024);
        run_fetch($urandom(), 0, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        run_fetch($urandom(), TIMEOUT_CYC - 1, 1'b0, 32'h0, 1, $urandom() & 32'hFFFF_FFFC, 32'h0);
        stray_ack();

        for (int i = 0; i < 30; i++) begin
            int          mode;
            int          delay;
            logic [31:0] v0;
            logic [31:0] v1;
            mode  = $urandom_range(3, 0);
            delay = $urandom_range(TIMEOUT_CYC - 1, 1);
            v0    = $urandom() & 32'hFFFF_FFFC;
            v1    = $urandom() & 32'hFFFF_FFFC;
            case (mode)
                0: run_fetch($urandom(), delay, 1'b0, 32'h0, 0, v0, v1);
                1: run_fetch($urandom(), delay, 1'b1, v0, 0, v0, v1);
                2: run_fetch($urandom(), delay, 1'b0, 32'h0, $urandom_range(2, 1), v0, v1);
                default: begin
                    load_pc(v0);
                    stray_ack();
                end
            endcase
            repeat ($urandom_range(2, 0)) @(posedge clk);
            #1;
        end

        // Misaligned next-PC
        do_reset();
        bus.pc_we = 1'b1;
        bus.npc   = 32'h0000_3002;
        @(posedge clk);
        #1;
        bus.pc_we = 1'b0;
`ifdef PCF_ALIGN_CHK_EN
        check("pc_unaligned_kept", bus.pc, 32'h0000_3002);
        bus.fetch_go = 1'b1;
        @(posedge clk);
        #1;
        bus.fetch_go = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("no_req_on_misalign", 32'(bus.imem_req), 32'd0);
            @(posedge clk);
            #1;
        end
        check("err_on_misalign", 32'(bus.fetch_err), 32'd1);
        check("ir_nop_on_misalign", bus.ir, NOP_INSTR);
`else
        check("pc_forced_aligned", bus.pc, 32'h0000_3000);
        m_pc = 32'h0000_3000;
        run_fetch($urandom(), 0, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        check("no_err_on_misalign", 32'(bus.fetch_err), 32'd0);
`endif

        // Acknowledge timeout
        do_reset();
        run_fetch(32'h1234_5678, 0, 1'b0, 32'h0, 0, 32'h0, 32'h0);
        addr_q.push_back(m_pc);
        bus.fetch_go = 1'b1;
        @(posedge clk);
        #1;
        bus.fetch_go = 1'b0;
        wait_req(ok);
        check("timeout_req_seen", 32'(ok), 32'd1);
        n = 0;
        while (bus.imem_req && n < 40) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("timeout_req_cycles", 32'(n), 32'(TIMEOUT_CYC));
        check("timeout_err", 32'(bus.fetch_err), 32'd1);
        check("timeout_ir_nop", bus.ir, NOP_INSTR);
        check("timeout_not_busy", 32'(bus.fetch_busy), 32'd0);
        bus.fetch_go = 1'b1;
        @(posedge clk);
        #1;
        bus.fetch_go = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("err_ignores_go", 32'(bus.imem_req), 32'd0);
            @(posedge clk);
            #1;
        end
        check("err_sticky", 32'(bus.fetch_err), 32'd1);

        // Reset in the middle of a request
        do_reset();
        load_pc(32'h0000_4440);
        addr_q.push_back(m_pc);
        bus.fetch_go = 1'b1;
        @(posedge clk);
        #1;
        bus.fetch_go = 1'b0;
        wait_req(ok);
        check("midrst_req_seen", 32'(ok), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_req_drop", 32'(bus.imem_req), 32'd0);
        check("midrst_pc", bus.pc, 32'h0000_3000);
        check("midrst_busy", 32'(bus.fetch_busy), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_pc = 32'h0000_3000;
        m_ir = NOP_INSTR;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_no_work_if", 32'(bus.work_IF), 32'd0);
        check("midrst_ir", bus.ir, m_ir);

        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        check("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
